// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle control unit.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ALU_R,
    CL_ALU_I,
    CL_LOAD,
    CL_STORE,
    CL_BNE,
    CL_BEQ,
    CL_LI,
    CL_JUMP,
    CL_HALT,
    CL_ILLEGAL
  } op_class_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_ADDI  = 4'd6;
  localparam logic [3:0] OP_ANDI  = 4'd7;
  localparam logic [3:0] OP_ORI   = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd10;
  localparam logic [3:0] OP_BNE   = 4'd11;
  localparam logic [3:0] OP_BEQ   = 4'd12;
  localparam logic [3:0] OP_LI    = 4'd13;
  localparam logic [3:0] OP_JUMP  = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode to instruction-class map; anything above 15 is illegal.
module opcode_class_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class
);

  // Upper bits beyond the 4-bit opcode space flag an illegal instruction.
  always_comb begin
    op_class = CL_ILLEGAL;
    if ((opcode >> 4) == '0) begin
      case (opcode[3:0])
        OP_NOP:                                 op_class = CL_NOP;
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:  op_class = CL_ALU_R;
        OP_ADDI, OP_ANDI, OP_ORI:               op_class = CL_ALU_I;
        OP_LOAD:                                op_class = CL_LOAD;
        OP_STORE:                               op_class = CL_STORE;
        OP_BNE:                                 op_class = CL_BNE;
        OP_BEQ:                                 op_class = CL_BEQ;
        OP_LI:                                  op_class = CL_LI;
        OP_JUMP:                                op_class = CL_JUMP;
        OP_HALT:                                op_class = CL_HALT;
        default:                                op_class = CL_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM with
// memory wait timeout, sticky trap flags and a retired-instruction counter.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                data_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src_branch,
  output logic                alu_src_imm,
  output logic                wb_sel_mem,
  output logic                reg_write,
  output logic                halted,
  output logic                illegal_op,
  output logic                timeout_err,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    instr_retired
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

  state_t            state_q;
  op_class_t         cls_q;
  op_class_t         dec_class;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_last;

  opcode_class_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_decoder (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  // The cycle that would bring the wait counter to WAIT_MAX without a ready.
  assign wait_last = (wait_cnt == WAIT_W'(WAIT_MAX - 1));

  // Sequencer: state, latched class, wait counter, sticky flags, retire count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      cls_q         <= CL_NOP;
      wait_cnt      <= '0;
      illegal_op    <= 1'b0;
      timeout_err   <= 1'b0;
      instr_retired <= '0;
    end else begin
      wait_cnt <= '0;
      case (state_q)
        ST_FETCH: begin
          if (mem_ready) begin
            state_q <= ST_DECODE;
          end else if (wait_last) begin
            state_q     <= ST_HALT;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          cls_q <= dec_class;
          case (dec_class)
            CL_NOP: begin
              state_q       <= ST_FETCH;
              instr_retired <= instr_retired + CNT_W'(1);
            end
            CL_HALT: begin
              state_q       <= ST_HALT;
              instr_retired <= instr_retired + CNT_W'(1);
            end
            CL_ILLEGAL: begin
              state_q    <= ST_HALT;
              illegal_op <= 1'b1;
            end
            default: state_q <= ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          case (cls_q)
            CL_BEQ, CL_BNE, CL_JUMP: begin
              state_q       <= ST_FETCH;
              instr_retired <= instr_retired + CNT_W'(1);
            end
            CL_LOAD, CL_STORE: state_q <= ST_MEM;
            default:           state_q <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (cls_q == CL_LOAD) begin
              state_q <= ST_WB;
            end else begin
              state_q       <= ST_FETCH;
              instr_retired <= instr_retired + CNT_W'(1);
            end
          end else if (wait_last) begin
            state_q     <= ST_HALT;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_WB: begin
          state_q       <= ST_FETCH;
          instr_retired <= instr_retired + CNT_W'(1);
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state and latched class.
  always_comb begin
    mem_read      = 1'b0;
    data_write    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src_branch = 1'b0;
    alu_src_imm   = 1'b0;
    wb_sel_mem    = 1'b0;
    reg_write     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ST_EXEC: begin
        alu_src_imm = (cls_q == CL_ALU_I) || (cls_q == CL_LI) ||
                      (cls_q == CL_LOAD)  || (cls_q == CL_STORE);
        case (cls_q)
          CL_BEQ: begin
            pc_write      = zero;
            pc_src_branch = 1'b1;
          end
          CL_BNE: begin
            pc_write      = ~zero;
            pc_src_branch = 1'b1;
          end
          CL_JUMP: begin
            pc_write      = 1'b1;
            pc_src_branch = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_read   = (cls_q == CL_LOAD);
        data_write = (cls_q == CL_STORE);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        wb_sel_mem = (cls_q == CL_LOAD);
      end
      default: ;
    endcase
  end

  assign halted = (state_q == ST_HALT);
  assign state  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction walks, memory waits,
// timeout, illegal opcode trap, reset recovery and counter wrap.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic        mem_read, data_write, ir_write, pc_write, pc_src_branch;
  logic        alu_src_imm, wb_sel_mem, reg_write, halted, illegal_op, timeout_err;
  logic [2:0]  state;
  logic [15:0] instr_retired;

  logic        s_mem_read, s_data_write, s_ir_write, s_pc_write, s_pc_src_branch;
  logic        s_alu_src_imm, s_wb_sel_mem, s_reg_write, s_halted, s_illegal_op, s_timeout_err;
  logic [2:0]  s_state;
  logic [1:0]  s_instr_retired;
  logic [3:0]  opcode_s;

  int tests = 0;
  int fails = 0;
  int exp_ret = 0;
  int cycles;

  assign opcode_s = opcode[3:0];

  always #5 clk = ~clk;

  multicycle_controller #(.OPCODE_W(5), .WAIT_MAX(15), .CNT_W(16)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_read      (mem_read),
    .data_write    (data_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src_branch (pc_src_branch),
    .alu_src_imm   (alu_src_imm),
    .wb_sel_mem    (wb_sel_mem),
    .reg_write     (reg_write),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .timeout_err   (timeout_err),
    .state         (state),
    .instr_retired (instr_retired)
  );

  multicycle_controller #(.OPCODE_W(4), .WAIT_MAX(15), .CNT_W(2)) u_small (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode_s),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_read      (s_mem_read),
    .data_write    (s_data_write),
    .ir_write      (s_ir_write),
    .pc_write      (s_pc_write),
    .pc_src_branch (s_pc_src_branch),
    .alu_src_imm   (s_alu_src_imm),
    .wb_sel_mem    (s_wb_sel_mem),
    .reg_write     (s_reg_write),
    .halted        (s_halted),
    .illegal_op    (s_illegal_op),
    .timeout_err   (s_timeout_err),
    .state         (s_state),
    .instr_retired (s_instr_retired)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    opcode = 5'd0;
    tick();
    reset = 1'b0;
    #1;
    exp_ret = 0;
  endtask

  // FETCH with ready, then DECODE; leaves the FSM one cycle past DECODE.
  task automatic fetch_decode(input logic [4:0] op);
    opcode = op;
    mem_ready = 1'b1;
    #1;
    chk("fetch_state", 32'(state), 32'd0);
    chk("fetch_ir_write", 32'(ir_write), 32'd1);
    chk("fetch_pc_write", 32'(pc_write), 32'd1);
    chk("fetch_pc_src", 32'(pc_src_branch), 32'd0);
    tick();
    chk("decode_state", 32'(state), 32'd1);
    chk("decode_mem_read", 32'(mem_read), 32'd0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    opcode = 5'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd1);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_flags", {29'd0, halted, illegal_op, timeout_err}, 32'd0);
    chk("rst_retired", 32'(instr_retired), 32'd0);

    // ALU_R: F D E WB
    fetch_decode(5'd1);
    chk("alur_exec_state", 32'(state), 32'd2);
    chk("alur_exec_regw", 32'(reg_write), 32'd0);
    chk("alur_exec_imm", 32'(alu_src_imm), 32'd0);
    tick();
    chk("alur_wb_state", 32'(state), 32'd4);
    chk("alur_wb_regw", 32'(reg_write), 32'd1);
    chk("alur_wb_selmem", 32'(wb_sel_mem), 32'd0);
    chk("alur_ret_before", 32'(instr_retired), 32'd0);
    tick();
    chk("alur_ret_after", 32'(instr_retired), 32'd1);
    chk("alur_back_fetch", 32'(state), 32'd0);

    // LOAD with three wait cycles in MEM: 8 cycles total
    cycles = 2;
    fetch_decode(5'd9);
    chk("load_exec_imm", 32'(alu_src_imm), 32'd1);
    tick(); cycles++;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("load_mem_state", 32'(state), 32'd3);
      chk("load_mem_read", 32'(mem_read), 32'd1);
      chk("load_mem_dw", 32'(data_write), 32'd0);
      tick(); cycles++;
    end
    mem_ready = 1'b1;
    #1;
    chk("load_mem_read_rdy", 32'(mem_read), 32'd1);
    tick(); cycles++;
    chk("load_wb_state", 32'(state), 32'd4);
    chk("load_wb_selmem", 32'(wb_sel_mem), 32'd1);
    chk("load_wb_regw", 32'(reg_write), 32'd1);
    tick(); cycles++;
    chk("load_cycles", 32'(cycles), 32'd8);
    chk("load_ret", 32'(instr_retired), 32'd2);
    chk("load_fetch", 32'(state), 32'd0);

    // Branches and jump resolve in EXEC
    fetch_decode(5'd12);
    zero = 1'b1;
    #1;
    chk("beq_z1_pcw", 32'(pc_write), 32'd1);
    chk("beq_z1_src", 32'(pc_src_branch), 32'd1);
    tick();
    chk("beq_z1_ret", 32'(instr_retired), 32'd3);
    chk("beq_z1_fetch", 32'(state), 32'd0);
    fetch_decode(5'd12);
    zero = 1'b0;
    #1;
    chk("beq_z0_pcw", 32'(pc_write), 32'd0);
    chk("beq_z0_src", 32'(pc_src_branch), 32'd1);
    tick();
    chk("beq_z0_ret", 32'(instr_retired), 32'd4);
    fetch_decode(5'd11);
    #1;
    chk("bne_z0_pcw", 32'(pc_write), 32'd1);
    tick();
    fetch_decode(5'd14);
    zero = 1'b1;
    #1;
    chk("jump_pcw", 32'(pc_write), 32'd1);
    chk("jump_src", 32'(pc_src_branch), 32'd1);
    tick();
    chk("jump_ret", 32'(instr_retired), 32'd6);
    zero = 1'b0;

    // STORE with one wait in MEM
    fetch_decode(5'd10);
    chk("store_exec_imm", 32'(alu_src_imm), 32'd1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("store_mem_dw", 32'(data_write), 32'd1);
    chk("store_mem_rd", 32'(mem_read), 32'd0);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("store_mem_dw_rdy", 32'(data_write), 32'd1);
    tick();
    chk("store_fetch", 32'(state), 32'd0);
    chk("store_ret", 32'(instr_retired), 32'd7);

    // LI: immediate operand, writeback from ALU
    fetch_decode(5'd13);
    chk("li_exec_imm", 32'(alu_src_imm), 32'd1);
    tick();
    chk("li_wb_regw", 32'(reg_write), 32'd1);
    chk("li_wb_selmem", 32'(wb_sel_mem), 32'd0);
    tick();
    chk("li_ret", 32'(instr_retired), 32'd8);

    // Ready on the last allowed wait cycle rescues the fetch
    mem_ready = 1'b0;
    opcode = 5'd0;
    for (int i = 0; i < 14; i++) tick();
    chk("rescue_still_fetch", 32'(state), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("rescue_ir_write", 32'(ir_write), 32'd1);
    tick();
    chk("rescue_decode", 32'(state), 32'd1);
    chk("rescue_no_timeout", 32'(timeout_err), 32'd0);
    tick();
    chk("rescue_nop_ret", 32'(instr_retired), 32'd9);

    // Fifteen waits without ready trips the timeout
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("to_before_state", 32'(state), 32'd0);
    tick();
    chk("to_state", 32'(state), 32'd5);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_illegal", 32'(illegal_op), 32'd0);
    chk("to_mem_read", 32'(mem_read), 32'd0);
    mem_ready = 1'b1;
    tick();
    tick();
    chk("to_stuck", 32'(state), 32'd5);
    chk("to_enables", {24'd0, mem_read, data_write, ir_write, pc_write,
                       reg_write, pc_src_branch, alu_src_imm, wb_sel_mem}, 32'd0);
    chk("to_ret_held", 32'(instr_retired), 32'd9);

    // Reset out of HALT clears everything
    do_reset();
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_flags", {29'd0, halted, illegal_op, timeout_err}, 32'd0);
    chk("rst2_ret", 32'(instr_retired), 32'd0);

    // NOP then HALT opcode: both retire
    fetch_decode(5'd0);
    chk("nop_ret", 32'(instr_retired), 32'd1);
    chk("nop_fetch", 32'(state), 32'd0);
    fetch_decode(5'd15);
    chk("halt_state", 32'(state), 32'd5);
    chk("halt_ret", 32'(instr_retired), 32'd2);
    chk("halt_illegal", 32'(illegal_op), 32'd0);
    chk("halt_halted", 32'(halted), 32'd1);

    // Illegal opcode 17 traps without retiring
    do_reset();
    fetch_decode(5'd0);
    fetch_decode(5'd17);
    chk("ill_state", 32'(state), 32'd5);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_ret", 32'(instr_retired), 32'd1);
    chk("ill_timeout", 32'(timeout_err), 32'd0);
    do_reset();
    chk("ill_rst_state", 32'(state), 32'd0);
    chk("ill_rst_flags", {29'd0, halted, illegal_op, timeout_err}, 32'd0);

    // Two-bit counter wraps after four NOPs
    for (int i = 1; i <= 4; i++) begin
      fetch_decode(5'd0);
      chk("wrap_small", 32'(s_instr_retired), 32'(i % 4));
      chk("wrap_main", 32'(instr_retired), 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control unit for the RISC CPU. It replaces the single-cycle opcode-to-control-word decode with a sequenced fetch/decode/execute/memory/writeback FSM.
- It adds a memory ready handshake with a wait timeout, branch resolution against the ALU zero flag, a sticky halt/illegal-opcode trap, and a retired-instruction counter.
- It sits between the instruction register and the datapath mux/write-enable inputs.

Parameters:
- OPCODE_W, 4, opcode width. Must be ≥4. Values ≥16 are illegal opcodes.
- WAIT_MAX, 15, maximum consecutive cycles in a memory wait before timeout.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  opcode field of the current instruction register; sampled in DECODE only
- zero  in  1  ALU zero flag; sampled in EXEC only
- mem_ready  in  1  memory completes the current read or write this cycle
- mem_read  out  1  memory read request (instruction fetch or load)
- data_write  out  1  data-memory write request (store)
- ir_write  out  1  instruction register load enable
- pc_write  out  1  PC update enable
- pc_src_branch  out  1  PC source: 1 selects the branch/jump target, 0 selects PC+1
- alu_src_imm  out  1  ALU B operand is the immediate
- wb_sel_mem  out  1  register writeback source is memory data
- reg_write  out  1  register file write enable
- halted  out  1  sticky: HALT state reached
- illegal_op  out  1  sticky: halt caused by an illegal opcode
- timeout_err  out  1  sticky: halt caused by a memory wait timeout
- state  out  3  current FSM state, for debug
- instr_retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W

Behaviour:
- Reset state:
  - state=FETCH; all sticky flags=0; instr_retired=0; wait counter=0; latched class=NOP.
  - Every output is a Moore decode of the state register plus the latched class. Enables follow that decode, so out of reset mem_read=1 and all other enables=0.
- Opcode classes:
  - 0: NOP.
  - 1–5: ALU_R.
  - 6–8: ALU_I.
  - 9: LOAD.
  - 10: STORE.
  - 11: BNE.
  - 12: BEQ.
  - 13: LI (imm→reg).
  - 14: JUMP.
  - 15: HALT.
  - ≥16: ILLEGAL.
- FETCH:
  - mem_read=1.
  - When mem_ready=1: ir_write=1 and pc_write=1 (pc_src_branch=0) in that same cycle, then go to DECODE.
- DECODE (1 cycle):
  - Latch the class of opcode.
  - NOP → FETCH, and retires.
  - HALT → HALT, and retires.
  - ILLEGAL → HALT, sets illegal_op, does not retire.
  - All other classes → EXEC.
- EXEC (1 cycle):
  - ALU_I, LI, LOAD, STORE: alu_src_imm=1.
  - BEQ: pc_write=zero, pc_src_branch=1. BNE: pc_write=~zero, pc_src_branch=1. JUMP: pc_write=1, pc_src_branch=1. These three → FETCH and retire.
  - LOAD, STORE → MEM.
  - ALU_R, ALU_I, LI → WB.
- MEM:
  - LOAD: mem_read=1. STORE: data_write=1.
  - On mem_ready: LOAD → WB; STORE → FETCH and retires.
- WB (1 cycle):
  - reg_write=1; wb_sel_mem=1 only for LOAD.
  - → FETCH, and retires.
- HALT:
  - All enables=0; halted=1.
  - Leaves only on reset.
- Wait timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle in that state while mem_ready=0.
  - If the counter reaches WAIT_MAX with mem_ready still 0 → HALT, timeout_err=1.
  - mem_ready=1 on the same cycle the counter reaches WAIT_MAX wins; no timeout.
- Latency with mem_ready always 1:
  - NOP/HALT: 2 cycles.
  - Branch/JUMP: 3 cycles.
  - ALU/LI/STORE: 4 cycles.
  - LOAD: 5 cycles.
- Retire: instr_retired increments by 1 on the cycle the retiring transition is taken; 2^CNT_W−1 wraps to 0.
- Reset mid-operation: reset in any state, including mid-wait or HALT, returns to FETCH next cycle with all counters and flags cleared. In-flight requests are dropped.
- mem_read and data_write are never both 1. Write enables are never asserted in HALT.

Decomposition:
- Shared package ctrl_pkg:
  - state enum FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
  - op_class enum.
  - opcode constants 0–15.
- One natural sub-module: opcode_class_decoder, a purely combinational opcode→op_class map, parametrised by OPCODE_W.

Test Plan:
- ALU_R opcode 1, mem_ready held 1 → states FETCH, DECODE, EXEC, WB; reg_write=1 only in cycle 4; instr_retired 0→1.
- LOAD opcode 9, mem_ready low for 3 cycles in MEM → mem_read=1 for 4 MEM cycles; then WB with wb_sel_mem=1; total 8 cycles.
- BEQ opcode 12 with zero=1, then BEQ with zero=0 → pc_write=1 and pc_src_branch=1 in the first EXEC; pc_write=0 in the second EXEC.
- FETCH with mem_ready stuck 0, WAIT_MAX=15 → HALT entered after 15 wait cycles; timeout_err=1, halted=1; mem_ready=1 on cycle 15 instead gives no timeout.
- OPCODE_W=5, opcode 17 → HALT with illegal_op=1 and instr_retired unchanged; then reset → FETCH and all flags cleared.
- CNT_W=2, 4 NOPs → instr_retired sequence 1, 2, 3, 0.
